cos_arbiter: RTL and testbench

COS_ARBITER -- requirements
Module: cos_arbiter

---
 rtl/cos_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/cos_arbiter.sv | 156 +++++++++++++++
 tb/tb_cos_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cos_arb_pkg.sv
// cos_arb_pkg: shared state encoding, width default and requester id type
// for the two-requester cosine-core arbiter.
package cos_arb_pkg;

    localparam int COS_ARB_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } cos_arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester that was not
// granted last wins.
module rr_arb2
    import cos_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  req_id_t    last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (req0_i && req1_i) begin
            grant_o = (last_i == REQ1) ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            grant_o = 2'b01;
        end else if (req1_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/cos_arbiter.sv
// cos_arbiter: shares one cosine core between two requesters with round-robin grant.
// Define COS_ARB_TIMEOUT_EN to enable the watchdog that aborts a stalled core computation.
module cos_arbiter
    import cos_arb_pkg::*;
#(
    parameter int WIDTH   = COS_ARB_WIDTH,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] w_out,
    output logic             err,
    output logic             busy,
    output logic             core_start,
    output logic [WIDTH-1:0] core_x,
    output logic [WIDTH-1:0] core_y,
    input  logic             core_ready,
    input  logic [WIDTH-1:0] core_w
);

    cos_arb_state_e   state_q, state_d;
    req_id_t          owner_q, owner_d;
    req_id_t          last_q, last_d;
    logic [WIDTH-1:0] core_x_q, core_x_d;
    logic [WIDTH-1:0] core_y_q, core_y_d;
    logic [WIDTH-1:0] w_out_q, w_out_d;
    logic [1:0]       grant;
    logic             timeout_hit;

    rr_arb2 u_rr_arb2 (
        .req0_i  (req0),
        .req1_i  (req1),
        .last_i  (last_q),
        .grant_o (grant)
    );

`ifdef COS_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            waiting;

    assign waiting = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

    // A core result arriving in the final allowed cycle still wins over the watchdog.
    assign timeout_hit = waiting && (cnt_q == CntW'(TIMEOUT - 1))
                         && !((state_q == WAIT_DONE) && core_ready);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == RESP) begin
            err_d = 1'b0;
        end else if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        core_x_d = core_x_q;
        core_y_d = core_y_q;
        w_out_d  = w_out_q;
        unique case (state_q)
            IDLE: begin
                if ((req0 || req1) && core_ready) begin
                    owner_d  = grant[1];
                    last_d   = grant[1];
                    core_x_d = grant[0] ? x0 : x1;
                    core_y_d = grant[0] ? y0 : y1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (timeout_hit) begin
                    w_out_d = '0;
                    state_d = RESP;
                end else if (!core_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_ready) begin
                    w_out_d = core_w;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    w_out_d = '0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Last-grant pointer resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= REQ0;
            last_q   <= REQ1;
            core_x_q <= '0;
            core_y_q <= '0;
            w_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            core_x_q <= core_x_d;
            core_y_q <= core_y_d;
            w_out_q  <= w_out_d;
        end
    end

    assign core_start = (state_q == ISSUE);
    assign core_x     = core_x_q;
    assign core_y     = core_y_q;
    assign w_out      = w_out_q;
    assign busy       = (state_q != IDLE);
    assign done0      = (state_q == RESP) && (owner_q == REQ0);
    assign done1      = (state_q == RESP) && (owner_q == REQ1);

endmodule

// File: tb/tb_cos_arbiter.sv
// tb_cos_arbiter: scoreboard bench with a behavioural cosine-core model and a
// round-robin reference model; honours COS_ARB_TIMEOUT_EN like the design.
module tb_cos_arbiter;

    typedef struct {
        bit          id;
        logic [15:0] w;
        bit          err;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] x0, y0, x1, y1;
    logic        done0, done1;
    logic [15:0] w_out;
    logic        err, busy, core_start;
    logic [15:0] core_x, core_y;
    logic        coreReady;
    logic [15:0] coreW;

    exp_t        scoreQ[$];
    op_t         opQ[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          startPulses = 0;
    int          expStarts  = 0;
    bit          modelLast  = 1'b1;
    logic [15:0] lastW      = '0;
    int          forcedLat  = 0;
    bit          fixedW     = 1'b0;
    bit          coreHang   = 1'b0;
    bit          abortTx    = 1'b0;

    cos_arbiter #(.WIDTH(16), .TIMEOUT(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .done0      (done0),
        .done1      (done1),
        .w_out      (w_out),
        .err        (err),
        .busy       (busy),
        .core_start (core_start),
        .core_x     (core_x),
        .core_y     (core_y),
        .core_ready (coreReady),
        .core_w     (coreW)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] coreFunc(input logic [15:0] x, input logic [15:0] y);
        return (x * 16'd3) ^ {y[7:0], y[15:8]} ^ 16'h1234;
    endfunction

    // Round-robin rule: a lone request wins; a tie goes to whoever was not served last.
    function automatic bit pickWinner(input bit r0, input bit r1);
        if (r0 && r1) return !modelLast;
        return r1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic flagFail(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic checkResetValues();
        checkOutput("rstDone0", 32'(done0), 0);
        checkOutput("rstDone1", 32'(done1), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstErr", 32'(err), 0);
        checkOutput("rstStart", 32'(core_start), 0);
        checkOutput("rstWOut", 32'(w_out), 0);
        checkOutput("rstCoreX", 32'(core_x), 0);
        checkOutput("rstCoreY", 32'(core_y), 0);
    endtask

    task automatic randomizeOperands();
        x0 = 16'($urandom);
        y0 = 16'($urandom);
        x1 = 16'($urandom);
        y1 = 16'($urandom);
    endtask

    task automatic waitBusy();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) return;
        end
        flagFail("busyTimeout", 32'(busy), 1);
    endtask

    task automatic waitDones(input int n);
        int seen = 0;
        for (int i = 0; i < 100 * n && seen < n; i++) begin
            @(negedge clk);
            if (done0 || done1) seen++;
        end
        if (seen < n) flagFail("doneTimeout", seen, n);
    endtask

    task automatic pulseReset();
        @(posedge clk); #1;
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        modelLast = 1'b1;
        lastW     = '0;
    endtask

    // Predicts every grant for the held request pattern, then runs it to completion.
    task automatic applyStimulus(input bit r0, input bit r1, input int nHold);
        exp_t e;
        op_t  op;
        bit   win;
        @(posedge clk); #1;
        req0 = r0;
        req1 = r1;
        for (int k = 0; k < nHold; k++) begin
            win       = pickWinner(r0, r1);
            modelLast = win;
            op.x  = win ? x1 : x0;
            op.y  = win ? y1 : y0;
            e.id  = win;
            e.w   = fixedW ? 16'h1234 : coreFunc(op.x, op.y);
            e.err = 1'b0;
            scoreQ.push_back(e);
            opQ.push_back(op);
            expStarts++;
            lastW = e.w;
        end
        if (nHold == 1) begin
            waitBusy();
            @(posedge clk); #1;
            x0 = 16'h000A;
            y0 = 16'($urandom);
            x1 = 16'($urandom);
            y1 = 16'($urandom);
        end
        waitDones(nHold);
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("wOutHold", 32'(w_out), 32'(lastW));
        checkOutput("busyIdle", 32'(busy), 0);
    endtask

    // Core model: drops ready after a start, returns a result after a latency.
    initial begin : coreModel
        op_t op;
        int  lat;
        bit  skipHeld;
        coreReady = 1'b1;
        coreW     = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                skipHeld = abortTx || coreHang;
                if (opQ.size() == 0) begin
                    flagFail("unexpectedStart", 1, 0);
                    skipHeld = 1'b1;
                end else begin
                    op = opQ.pop_front();
                    checkOutput("coreXAtStart", 32'(core_x), 32'(op.x));
                    checkOutput("coreYAtStart", 32'(core_y), 32'(op.y));
                end
                lat = (forcedLat > 0) ? forcedLat : $urandom_range(1, 5);
                @(posedge clk); #1;
                coreReady = 1'b0;
                if (coreHang) begin
                    while (coreHang) @(posedge clk);
                end else begin
                    repeat (lat) @(posedge clk);
                end
                #1;
                if (!skipHeld) begin
                    checkOutput("coreXHeld", 32'(core_x), 32'(op.x));
                    checkOutput("coreYHeld", 32'(core_y), 32'(op.y));
                end
                coreW     = fixedW ? 16'h1234 : coreFunc(core_x, core_y);
                coreReady = 1'b1;
            end
        end
    end

    // Monitor: every done pulse pops one expected response.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) startPulses++;
            if (done0 === 1'b1 || done1 === 1'b1) begin
                checkOutput("doneExclusive", 32'(done0 & done1), 0);
                if (scoreQ.size() == 0) begin
                    flagFail("unexpectedDone", {30'b0, done1, done0}, 0);
                end else begin
                    e = scoreQ.pop_front();
                    checkOutput("doneId", 32'(done1), 32'(e.id));
                    checkOutput("wOut", 32'(w_out), 32'(e.w));
                    checkOutput("errFlag", 32'(err), 32'(e.err));
                end
            end
        end
    end

    initial begin : driver
        exp_t e;
        op_t  op;
        int   cycles;
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues();
        @(posedge clk); #1;
        rst = 1'b0;

        // Tie from reset: 0 then 1, then a fresh tie goes to 0 again.
        randomizeOperands();
        applyStimulus(1'b1, 1'b1, 2);
        randomizeOperands();
        applyStimulus(1'b1, 1'b1, 1);

        x0 = 16'h010B;
        y0 = 16'h0066;
        fixedW    = 1'b1;
        forcedLat = 10;
        applyStimulus(1'b1, 1'b0, 1);
        fixedW    = 1'b0;
        forcedLat = 0;

        randomizeOperands();
        applyStimulus(1'b0, 1'b1, 4);

        // Reset during WAIT_DONE abandons the transaction silently.
        randomizeOperands();
        forcedLat = 8;
        abortTx   = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b1;
        op.x = x0;
        op.y = y0;
        opQ.push_back(op);
        expStarts++;
        waitBusy();
        repeat (3) @(posedge clk);
        pulseReset();
        @(negedge clk);
        checkResetValues();
        repeat (12) @(posedge clk);
        forcedLat = 0;
        abortTx   = 1'b0;
        randomizeOperands();
        applyStimulus(1'b1, 1'b1, 1);

        for (int t = 0; t < 14; t++) begin
            int p;
            p = $urandom_range(1, 3);
            randomizeOperands();
            applyStimulus(p[0], p[1], $urandom_range(1, 2));
        end

        randomizeOperands();
        coreHang = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b1;
        op.x = x0;
        op.y = y0;
        opQ.push_back(op);
        expStarts++;
        waitBusy();
`ifdef COS_ARB_TIMEOUT_EN
        modelLast = 1'b0;
        e.id  = 1'b0;
        e.w   = '0;
        e.err = 1'b1;
        scoreQ.push_back(e);
        lastW  = '0;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles++;
            if (done0) break;
        end
        checkOutput("timeoutLatency", cycles, 21);
        @(posedge clk); #1;
        req0     = 1'b0;
        coreHang = 1'b0;
        repeat (4) @(posedge clk);
`else
        repeat (40) @(negedge clk);
        checkOutput("busyStuck", 32'(busy), 1);
        checkOutput("errTiedLow", 32'(err), 0);
        checkOutput("wOutDuringWait", 32'(w_out), 32'(lastW));
        abortTx = 1'b1;
        pulseReset();
        coreHang = 1'b0;
        repeat (4) @(posedge clk);
        abortTx = 1'b0;
`endif
        randomizeOperands();
        applyStimulus(1'b1, 1'b1, 2);

        repeat (5) @(posedge clk);
        checkOutput("pendingExpected", scoreQ.size(), 0);
        checkOutput("coreStartCount", startPulses, expStarts);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL globalTimeout: simulation exceeded its time budget");
        $fatal(1, "[TB] stopped by watchdog");
    end

endmodule
